// File: rtl/mtip_link_ctrl_if.sv
// Signal bundle between the link bring-up controller and its environment
// (link request/status, PHY status and the core register write port).
interface mtip_link_ctrl_if;
  // Requests and PHY status, driven by the environment
  logic        enable;
  logic        scrb_pref;
  logic        rx_phy_los;
  logic        comma_det;
  logic        sync_acqurd;
  logic        reg_busy;

  // Register write port and link status, driven by the controller
  logic        reg_wr;
  logic [9:2]  reg_addr;
  logic [31:0] reg_wdata;
  logic        link_up;
  logic [2:0]  link_state;
  logic        scrb_ena;
  logic [3:0]  retry_cnt;
  logic        fail;
  logic [15:0] link_drop_cnt;

  // Controller side
  modport master (
    input  enable, scrb_pref, rx_phy_los, comma_det, sync_acqurd, reg_busy,
    output reg_wr, reg_addr, reg_wdata, link_up, link_state, scrb_ena,
           retry_cnt, fail, link_drop_cnt
  );

  // Environment side
  modport slave (
    output enable, scrb_pref, rx_phy_los, comma_det, sync_acqurd, reg_busy,
    input  reg_wr, reg_addr, reg_wdata, link_up, link_state, scrb_ena,
           retry_cnt, fail, link_drop_cnt
  );
endinterface

// File: rtl/mtip_link_ctrl.sv
// Link bring-up controller: programs the core command-config register to
// enable comma detection, waits for sync, qualifies it for a stable period,
// then locks alignment. Retries with alternating scrambler setting on
// acquisition timeout and counts link drops once up.
module mtip_link_ctrl #(
  parameter logic [19:0] ACQ_TIMEOUT = 20'd65536,
  parameter logic [15:0] STABLE_CNT  = 16'd1024,
  parameter logic [3:0]  MAX_RETRY   = 4'd3
) (
  input  logic              reg_clk,
  input  logic              reset_reg_clk,
  mtip_link_ctrl_if.master  bus
);

  localparam int unsigned TMR_W  = 20;
  localparam int unsigned STB_W  = 16;
  localparam int unsigned RTY_W  = 4;
  localparam int unsigned DRP_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  CFG_ADDR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ALIGN  = 3'd1,
    ST_WAIT_SYNC = 3'd2,
    ST_QUALIFY   = 3'd3,
    ST_WR_LOCK   = 3'd4,
    ST_UP        = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  state_e              state_q;
  logic [TMR_W-1:0]    timer_q,  timer_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic [RTY_W-1:0]    retry_q,  retry_d;
  logic [DRP_W-1:0]    link_drop_cnt_q, link_drop_cnt_d;
  logic                scrb_ena_q;
  logic                reg_wr_q;
  logic [DATA_W-1:0]   reg_wdata_q;
  logic [7:0]          reg_addr_q;
  logic                link_up_q;
  logic                fail_q;
  logic                timeout_hit;
  logic                qual_done;
  logic                drop_evt;

  // Command-config word: bit10 = ena_det, bit0 = scrb_ena
  function automatic logic [DATA_W-1:0] cfg_word(input logic ena_det, input logic scrb);
    return {21'd0, ena_det, 9'd0, scrb};
  endfunction

  // Counter increments, terminal-count decodes and the saturating drop count
  always_comb begin
    timer_d         = timer_q + TMR_W'(1);
    stable_d        = stable_q + STB_W'(1);
    retry_d         = retry_q + RTY_W'(1);
    timeout_hit     = (timer_q == (ACQ_TIMEOUT - TMR_W'(1)));
    qual_done       = (stable_q == (STABLE_CNT - STB_W'(1)));
    drop_evt        = bus.enable && (state_q == ST_UP) &&
                      (!bus.sync_acqurd || bus.rx_phy_los);
    link_drop_cnt_d = link_drop_cnt_q;
    if (drop_evt && (link_drop_cnt_q != '1)) begin
      link_drop_cnt_d = link_drop_cnt_q + DRP_W'(1);
    end
  end

  // Bring-up FSM with registered outputs; enable=0 overrides every state
  always_ff @(posedge reg_clk) begin
    if (reset_reg_clk) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      stable_q        <= '0;
      retry_q         <= '0;
      link_drop_cnt_q <= '0;
      scrb_ena_q      <= 1'b0;
      reg_wr_q        <= 1'b0;
      reg_wdata_q     <= '0;
      reg_addr_q      <= CFG_ADDR;
      link_up_q       <= 1'b0;
      fail_q          <= 1'b0;
    end else begin
      reg_wr_q        <= 1'b0;
      reg_addr_q      <= CFG_ADDR;
      link_drop_cnt_q <= link_drop_cnt_d;
      if (!bus.enable) begin
        state_q   <= ST_IDLE;
        link_up_q <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (!bus.rx_phy_los) begin
              state_q    <= ST_WR_ALIGN;
              scrb_ena_q <= bus.scrb_pref;
              retry_q    <= '0;
            end
          end

          ST_WR_ALIGN: begin
            // The gap on reg_wr_q keeps strobes from ever being back to back
            if (!bus.reg_busy && !reg_wr_q) begin
              reg_wr_q    <= 1'b1;
              reg_wdata_q <= cfg_word(1'b1, scrb_ena_q);
              timer_q     <= '0;
              state_q     <= ST_WAIT_SYNC;
            end
          end

          ST_WAIT_SYNC: begin
            if (bus.rx_phy_los) begin
              // Signal lost: restart the acquisition window, no retry consumed
              timer_q  <= '0;
              stable_q <= '0;
            end else if (timeout_hit) begin
              if (retry_q == MAX_RETRY) begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end else begin
                retry_q    <= retry_d;
                scrb_ena_q <= ~scrb_ena_q;
                state_q    <= ST_WR_ALIGN;
              end
            end else begin
              timer_q <= timer_d;
              if (bus.comma_det && bus.sync_acqurd) begin
                stable_q <= '0;
                state_q  <= ST_QUALIFY;
              end
            end
          end

          ST_QUALIFY: begin
            if (bus.rx_phy_los) begin
              timer_q  <= '0;
              stable_q <= '0;
              state_q  <= ST_WAIT_SYNC;
            end else if (!bus.sync_acqurd) begin
              // Sync glitch: resume waiting in the same acquisition window
              state_q <= ST_WAIT_SYNC;
            end else if (qual_done) begin
              state_q <= ST_WR_LOCK;
            end else begin
              stable_q <= stable_d;
            end
          end

          ST_WR_LOCK: begin
            if (!bus.reg_busy && !reg_wr_q) begin
              reg_wr_q    <= 1'b1;
              reg_wdata_q <= cfg_word(1'b0, scrb_ena_q);
              link_up_q   <= 1'b1;
              state_q     <= ST_UP;
            end
          end

          ST_UP: begin
            if (drop_evt) begin
              retry_q   <= '0;
              link_up_q <= 1'b0;
              state_q   <= ST_WR_ALIGN;
            end
          end

          ST_FAIL: begin
            fail_q <= 1'b1;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Drive the interface straight from registers
  assign bus.reg_wr        = reg_wr_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.link_up       = link_up_q;
  assign bus.link_state    = state_q;
  assign bus.scrb_ena      = scrb_ena_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.fail          = fail_q;
  assign bus.link_drop_cnt = link_drop_cnt_q;

endmodule

// File: tb/tb_mtip_link_ctrl.sv
// Directed bench for mtip_link_ctrl with ACQ_TIMEOUT=16, STABLE_CNT=4,
// MAX_RETRY=2. Inputs change and outputs are sampled on the falling edge.
module tb_mtip_link_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   consec_cnt = 0;
  logic prev_wr  = 1'b0;
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          n_before;

  mtip_link_ctrl_if bus();

  mtip_link_ctrl #(
    .ACQ_TIMEOUT (20'd16),
    .STABLE_CNT  (16'd4),
    .MAX_RETRY   (4'd2)
  ) dut (
    .reg_clk       (clk),
    .reset_reg_clk (rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Log every write strobe shortly after the edge that launched it
  always begin
    @(posedge clk);
    #2;
    if (bus.reg_wr) begin
      wr_data.push_back(bus.reg_wdata);
      wr_cyc.push_back(cyc_cnt);
      if (prev_wr) consec_cnt++;
    end
    prev_wr = bus.reg_wr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc);
    for (int i = 0; i < max_cyc && bus.link_state != st; i++) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.scrb_pref   = 1'b0;
    bus.rx_phy_los  = 1'b0;
    bus.comma_det   = 1'b0;
    bus.sync_acqurd = 1'b0;
    bus.reg_busy    = 1'b0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    check("rst_state", 32'(bus.link_state), 32'd0);
    check("rst_addr",  32'(bus.reg_addr), 32'h02);
    check("rst_wr",    32'(bus.reg_wr), 32'd0);
    check("rst_wdata", bus.reg_wdata, 32'd0);
    check("rst_drop",  32'(bus.link_drop_cnt), 32'd0);
    check("rst_up",    32'(bus.link_up), 32'd0);

    // Happy path
    bus.scrb_pref = 1'b1;
    bus.enable    = 1'b1;
    cyc(1);
    check("hp_align_st", 32'(bus.link_state), 32'd1);
    check("hp_scrb",     32'(bus.scrb_ena), 32'd1);
    cyc(1);
    check("hp_wr",       32'(bus.reg_wr), 32'd1);
    check("hp_wdata",    bus.reg_wdata, 32'h401);
    check("hp_wait_st",  32'(bus.link_state), 32'd2);
    cyc(3);
    bus.comma_det   = 1'b1;
    bus.sync_acqurd = 1'b1;
    wait_state(3'd5, 40);
    check("hp_up_st", 32'(bus.link_state), 32'd5);
    check("hp_up",    32'(bus.link_up), 32'd1);
    check("hp_retry", 32'(bus.retry_cnt), 32'd0);
    check("hp_nwr",   32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) begin
      check("hp_w0", wr_data[0], 32'h401);
      check("hp_w1", wr_data[1], 32'h001);
    end

    // Link drop in UP
    wr_data.delete();
    wr_cyc.delete();
    bus.sync_acqurd = 1'b0;
    cyc(1);
    check("drop_cnt",  32'(bus.link_drop_cnt), 32'd1);
    check("drop_st",   32'(bus.link_state), 32'd1);
    check("drop_up",   32'(bus.link_up), 32'd0);
    cyc(1);
    check("drop_wr",   32'(bus.reg_wr), 32'd1);
    check("drop_wdat", bus.reg_wdata, 32'h401);
    bus.sync_acqurd = 1'b1;
    wait_state(3'd5, 40);
    check("drop_reup", 32'(bus.link_state), 32'd5);

    // Drop counter saturation
    force dut.link_drop_cnt_q = 16'hFFFF;
    cyc(2);
    release dut.link_drop_cnt_q;
    cyc(1);
    bus.sync_acqurd = 1'b0;
    cyc(1);
    check("sat_cnt", 32'(bus.link_drop_cnt), 32'h0000FFFF);
    check("sat_st",  32'(bus.link_state), 32'd1);

    // enable=0 returns to IDLE, drop count retained
    bus.enable = 1'b0;
    cyc(1);
    check("dis_st",   32'(bus.link_state), 32'd0);
    check("dis_drop", 32'(bus.link_drop_cnt), 32'h0000FFFF);

    // Retry to FAIL: no sync ever
    bus.comma_det   = 1'b0;
    bus.sync_acqurd = 1'b0;
    wr_data.delete();
    wr_cyc.delete();
    bus.scrb_pref = 1'b1;
    bus.enable    = 1'b1;
    wait_state(3'd6, 120);
    check("rf_st",    32'(bus.link_state), 32'd6);
    check("rf_fail",  32'(bus.fail), 32'd1);
    check("rf_retry", 32'(bus.retry_cnt), 32'd2);
    check("rf_nwr",   32'(wr_data.size()), 32'd3);
    if (wr_data.size() == 3) begin
      check("rf_w0",  wr_data[0], 32'h401);
      check("rf_w1",  wr_data[1], 32'h400);
      check("rf_w2",  wr_data[2], 32'h401);
      check("rf_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd17);
    end
    bus.enable = 1'b0;
    cyc(1);
    check("rf_idle",   32'(bus.link_state), 32'd0);
    check("rf_fail0",  32'(bus.fail), 32'd0);
    check("rf_retain", 32'(bus.retry_cnt), 32'd2);
    check("rf_scrb",   32'(bus.scrb_ena), 32'd1);

    // reg_busy holds the align write
    wr_data.delete();
    wr_cyc.delete();
    bus.scrb_pref = 1'b0;
    bus.reg_busy  = 1'b1;
    bus.enable    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("busy_nowr", 32'(bus.reg_wr), 32'd0);
    end
    check("busy_st", 32'(bus.link_state), 32'd1);
    bus.reg_busy = 1'b0;
    cyc(1);
    check("busy_wr",    32'(bus.reg_wr), 32'd1);
    check("busy_wdata", bus.reg_wdata, 32'h400);
    check("busy_retry", 32'(bus.retry_cnt), 32'd0);

    // QUALIFY glitch then LOS pulse in WAIT_SYNC
    bus.comma_det   = 1'b1;
    bus.sync_acqurd = 1'b1;
    cyc(1);
    check("busy_pulse", 32'(bus.reg_wr), 32'd0);
    check("q_st",       32'(bus.link_state), 32'd3);
    check("busy_nwr",   32'(wr_data.size()), 32'd1);
    cyc(2);
    check("q_stable", 32'(dut.stable_q), 32'd2);
    bus.sync_acqurd = 1'b0;
    cyc(1);
    check("q_back_st", 32'(bus.link_state), 32'd2);
    check("q_timer",   32'(dut.timer_q), 32'd1);
    bus.rx_phy_los = 1'b1;
    cyc(1);
    check("los_timer0", 32'(dut.timer_q), 32'd0);
    check("los_st",     32'(bus.link_state), 32'd2);
    bus.rx_phy_los = 1'b0;
    cyc(1);
    check("los_timer1", 32'(dut.timer_q), 32'd1);
    check("los_retry",  32'(bus.retry_cnt), 32'd0);

    // Synchronous reset in WR_LOCK while busy
    bus.reg_busy    = 1'b1;
    bus.sync_acqurd = 1'b1;
    wait_state(3'd4, 30);
    check("lk_st", 32'(bus.link_state), 32'd4);
    n_before = wr_data.size();
    rst        = 1'b1;
    bus.enable = 1'b0;
    cyc(1);
    check("lr_st",    32'(bus.link_state), 32'd0);
    check("lr_wr",    32'(bus.reg_wr), 32'd0);
    check("lr_wdata", bus.reg_wdata, 32'd0);
    check("lr_drop",  32'(bus.link_drop_cnt), 32'd0);
    check("lr_addr",  32'(bus.reg_addr), 32'h02);
    rst          = 1'b0;
    bus.reg_busy = 1'b0;
    cyc(3);
    check("lr_nowr",  32'(wr_data.size()), 32'(n_before));
    check("no_b2b",   32'(consec_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
